// File: rtl/hamming_byte_assembler_if.sv
// Codeword input and byte output bus for hamming_byte_assembler.
//   ena        : input-side enable; code_valid is ignored when low
//   code_in    : 7-bit Hamming(7,4) codeword, bit 0 = first received bit
//   code_valid : one-cycle strobe qualifying code_in
//   byte_out   : FIFO head byte
//   byte_valid : FIFO non-empty
//   byte_ready : consumer accepts byte_out when byte_valid is high
// The master modport drives codewords and consumes bytes.
// The slave modport is the assembler.
interface hamming_byte_assembler_if;
  logic       ena;
  logic [6:0] code_in;
  logic       code_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output ena, code_in, code_valid, byte_ready,
    input  byte_out, byte_valid
  );

  modport slave (
    input  ena, code_in, code_valid, byte_ready,
    output byte_out, byte_valid
  );
endinterface

// File: rtl/hamming_byte_assembler.sv
// hamming_byte_assembler
// Decodes Hamming(7,4) codewords and pairs the nibbles into bytes, low nibble
// first. Finished bytes enter a DEPTH-entry FIFO with a ready/valid output.
// Optional feature macro: HAMMING_CORRECT_EN.
//   When it is defined, single-bit errors are corrected before the nibble is
//   extracted.
//   When it is undefined, the raw data bits {c6,c5,c4,c2} are used.
//   The syndrome still drives err_count in both builds.
// Ports:
//   clk, rst       : clock; synchronous active-high reset
//   bus (slave)    : ena, code_in, code_valid, byte_out, byte_valid, byte_ready
//   nibble_pending : a low nibble is held and waits for its high nibble
//   err_count      : saturating count of codewords with a nonzero syndrome
//   overflow       : sticky; a byte was dropped because the FIFO was full
//   fifo_level     : number of bytes stored
module hamming_byte_assembler #(
  parameter int DEPTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  hamming_byte_assembler_if.slave  bus,
  output logic                     nibble_pending,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [3:0]           low_nib_q, low_nib_d;
  logic                 pending_q, pending_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 ovf_q, ovf_d;

  logic [2:0] syn;
  logic [3:0] nibble;
  logic [6:0] fixed;
  logic       accept, push, pop, full;

  // Decode the codeword.
  always_comb begin
    syn = {bus.code_in[3] ^ bus.code_in[4] ^ bus.code_in[5] ^ bus.code_in[6],
           bus.code_in[1] ^ bus.code_in[2] ^ bus.code_in[5] ^ bus.code_in[6],
           bus.code_in[0] ^ bus.code_in[2] ^ bus.code_in[4] ^ bus.code_in[6]};
    fixed = bus.code_in;
`ifdef HAMMING_CORRECT_EN
    // A nonzero syndrome gives the 1-based position of the bit to flip.
    for (int unsigned i = 0; i < 7; i++) begin
      if (syn == 3'(i + 1)) fixed[i] = ~bus.code_in[i];
    end
`endif
    nibble = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

  always_comb begin
    accept = bus.code_valid && bus.ena;
    push   = accept && pending_q;
    pop    = (level_q != '0) && bus.byte_ready;
    full   = (level_q == LVL_W'(DEPTH));

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    low_nib_d = low_nib_q;
    pending_d = pending_q;
    err_d     = err_q;
    ovf_d     = ovf_q;

    if (accept) begin
      if (syn != '0 && err_q != '1) err_d = err_q + 1'b1;
      if (!pending_q) begin
        low_nib_d = nibble;
        pending_d = 1'b1;
      end else begin
        pending_d = 1'b0;
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // When the FIFO is full, a push is accepted only if a pop in the same
    // cycle frees the head slot. That pop reads the old head, so the slot at
    // wr_ptr (== rd_ptr when full) can be overwritten safely.
    if (push) begin
      if (!full || pop) begin
        mem_d[wr_ptr_q] = {nibble, low_nib_q};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case ({push && (!full || pop), pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      low_nib_q <= '0;
      pending_q <= 1'b0;
      err_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      low_nib_q <= low_nib_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.byte_out   = mem_q[rd_ptr_q];
  assign bus.byte_valid = (level_q != '0);
  assign nibble_pending = pending_q;
  assign err_count      = err_q;
  assign overflow       = ovf_q;
  assign fifo_level     = level_q;

endmodule

// File: tb/tb_hamming_byte_assembler.sv
module tb_hamming_byte_assembler;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hamming_byte_assembler_if bus();
  hamming_byte_assembler_if bus2();

  logic       pend, ovf, pend2, ovf2;
  logic [7:0] errc;
  logic [1:0] errc2;
  logic [2:0] lvl, lvl2;

  hamming_byte_assembler #(.DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .nibble_pending(pend),
    .err_count(errc), .overflow(ovf), .fifo_level(lvl)
  );

  hamming_byte_assembler #(.DEPTH(DEPTH), .ERR_CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .bus(bus2), .nibble_pending(pend2),
    .err_count(errc2), .overflow(ovf2), .fifo_level(lvl2)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural reference model.
  logic [7:0] m_q[$];
  bit         m_pend;
  logic [3:0] m_low;
  int         m_err8, m_err2;
  bit         m_ovf;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic p1, p2, p4;
    p1 = n[0] ^ n[1] ^ n[3];
    p2 = n[0] ^ n[2] ^ n[3];
    p4 = n[1] ^ n[2] ^ n[3];
    return {n[3], n[2], n[1], p4, n[0], p2, p1};
  endfunction

  function automatic bit is_err(input logic [6:0] c);
    for (int n = 0; n < 16; n++) if (enc(4'(n)) == c) return 1'b0;
    return 1'b1;
  endfunction

  // Decodes to the nearest codeword by Hamming distance, or uses the raw data bits.
  function automatic logic [3:0] ref_decode(input logic [6:0] c);
`ifdef HAMMING_CORRECT_EN
    int best, bestd, d;
    best = 0;
    bestd = 8;
    for (int n = 0; n < 16; n++) begin
      d = $countones(enc(4'(n)) ^ c);
      if (d < bestd) begin
        bestd = d;
        best = n;
      end
    end
    return 4'(best);
`else
    return {c[6], c[5], c[4], c[2]};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit v,
                            input logic [6:0] c, input bit rdy);
    bit pop, push, full;
    logic [7:0] b;
    if (r) begin
      m_q.delete();
      m_pend = 0;
      m_low = 0;
      m_err8 = 0;
      m_err2 = 0;
      m_ovf = 0;
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    push = 0;
    b = '0;
    if (e && v) begin
      if (is_err(c)) begin
        if (m_err8 < 255) m_err8++;
        if (m_err2 < 3) m_err2++;
      end
      if (!m_pend) begin
        m_low = ref_decode(c);
        m_pend = 1;
      end else begin
        m_pend = 0;
        b = {ref_decode(c), m_low};
        push = 1;
      end
    end
    full = (m_q.size() == DEPTH);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!full || pop) m_q.push_back(b);
      else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    check("byte_valid", 32'(bus.byte_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("byte_out", 32'(bus.byte_out), 32'(m_q[0]));
    check("fifo_level", 32'(lvl), 32'(m_q.size()));
    check("nibble_pending", 32'(pend), 32'(m_pend));
    check("err_count", 32'(errc), 32'(m_err8));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("err_count_w2", 32'(errc2), 32'(m_err2));
  endtask

  task automatic step(input bit r, input bit e, input bit v,
                      input logic [6:0] c, input bit rdy);
    rst = r;
    bus.ena = e;
    bus2.ena = e;
    bus.code_valid = v;
    bus2.code_valid = v;
    bus.code_in = c;
    bus2.code_in = c;
    bus.byte_ready = rdy;
    bus2.byte_ready = rdy;
    @(posedge clk);
    model_edge(r, e, v, c, rdy);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0);
  endtask

  task automatic send_pair(input logic [3:0] lo, input logic [3:0] hi, input bit rdy);
    step(0, 1, 1, enc(lo), rdy);
    step(0, 1, 1, enc(hi), rdy);
  endtask

  initial begin
    // Reset state
    do_reset(2);
    check("reset_byte_out", 32'(bus.byte_out), 32'h0);
    check("reset_level", 32'(lvl), 32'h0);

    // Clean pair
    step(0, 1, 1, 7'h2D, 1);
    step(0, 1, 1, 7'h52, 1);
    check("clean_byte", 32'(bus.byte_out), 32'hA5);
    check("clean_valid", 32'(bus.byte_valid), 32'h1);
    step(0, 0, 0, '0, 1);
    check("clean_one_cycle", 32'(bus.byte_valid), 32'h0);
    check("clean_err", 32'(errc), 32'h0);

    // Single-bit error on the high nibble
    step(0, 1, 1, 7'h2D, 1);
    step(0, 1, 1, 7'h42, 1);
`ifdef HAMMING_CORRECT_EN
    check("err_byte", 32'(bus.byte_out), 32'hA5);
`else
    check("err_byte", 32'(bus.byte_out), 32'h85);
`endif
    check("err_cnt1", 32'(errc), 32'h1);
    step(0, 0, 0, '0, 1);

    // Fill and overflow
    do_reset(1);
    for (int i = 0; i < 4; i++) send_pair(4'(i), 4'(i), 0);
    check("fill_level", 32'(lvl), 32'h4);
    send_pair(4'h4, 4'h4, 0);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_level", 32'(lvl), 32'h4);
    check("drain_head0", 32'(bus.byte_out), 32'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1);
    check("drained", 32'(lvl), 32'h0);

    // Full with simultaneous push and pop
    do_reset(1);
    for (int i = 0; i < 4; i++) send_pair(4'(i), 4'(i), 0);
    step(0, 1, 1, enc(4'h4), 0);
    step(0, 1, 1, enc(4'h4), 1);
    check("pp_level", 32'(lvl), 32'h4);
    check("pp_ovf", 32'(ovf), 32'h0);
    check("pp_head", 32'(bus.byte_out), 32'h11);
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1);

    // Enable and reset mid-pair
    do_reset(1);
    step(0, 1, 1, 7'h2D, 1);
    check("mid_pend", 32'(pend), 32'h1);
    step(0, 0, 1, 7'h52, 1);
    check("ena_ignored", 32'(pend), 32'h1);
    do_reset(1);
    check("rst_pend", 32'(pend), 32'h0);
    step(0, 1, 1, 7'h2D, 1);
    step(0, 1, 1, 7'h52, 1);
    check("after_rst_byte", 32'(bus.byte_out), 32'hA5);
    step(0, 0, 0, '0, 1);

    // err_count saturation
    do_reset(1);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 7'h42, 0);
    check("sat_w2", 32'(errc2), 32'h3);
    check("sat_w8", 32'(errc), 32'h5);

    // Randomized traffic
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      logic [6:0] c;
      if ($urandom_range(0, 1) == 0) c = enc(4'($urandom));
      else c = 7'($urandom);
      step($urandom_range(0, 79) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 2) != 0, c, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
